// File: rtl/lfsr_pkg.sv
// Shared types, default constants and the LFSR step function for the
// shared-PRNG arbiter.
package lfsr_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ADVANCE = 2'd1,
    DELIVER = 2'd2
  } state_t;

  localparam logic [31:0] DEFAULT_TAPS = 32'h80200003;
  localparam logic [31:0] DEFAULT_SEED = 32'h00000001;

  // Widest LFSR the step function supports; callers widen/truncate around it.
  localparam int LFSR_MAX_W = 64;

  // One Fibonacci shift: feedback is the parity of the tapped bits,
  // shifted in at bit 0; bits above 'width' are forced to zero.
  function automatic logic [LFSR_MAX_W-1:0] lfsr_next(
    input logic [LFSR_MAX_W-1:0] value,
    input logic [LFSR_MAX_W-1:0] taps,
    input int                    width
  );
    logic [LFSR_MAX_W-1:0] mask;
    logic                  fb;
    mask = {LFSR_MAX_W{1'b1}} >> (LFSR_MAX_W - width);
    fb   = ^(value & taps & mask);
    return ((value << 1) | {{(LFSR_MAX_W-1){1'b0}}, fb}) & mask;
  endfunction

endpackage

// File: rtl/lfsr_rr_pick.sv
// Combinational round-robin picker: finds the first asserted request at or
// after rr_ptr, wrapping around modulo NREQ.
module lfsr_rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  rr_ptr,
  output logic            any,
  output logic [IDW-1:0]  idx
);

  // Scan from farthest to nearest so the nearest asserted request wins.
  always_comb begin
    int pos;
    pos = 0;
    any = 1'b0;
    idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      pos = (int'(rr_ptr) + k) % NREQ;
      if (req[pos]) begin
        any = 1'b1;
        idx = IDW'(pos);
      end
    end
  end

endmodule

// File: rtl/lfsr_rng_arbiter.sv
// One LFSR shared among NREQ requesters: round-robin selection, STEPS
// decorrelation shifts, then a single-cycle registered delivery with a
// one-hot grant. Optional macro LFSR_FREE_RUN_EN makes the LFSR also step
// in every IDLE cycle without a seed load.
module lfsr_rng_arbiter
  import lfsr_pkg::*;
#(
  parameter int               WIDTH = 32,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(DEFAULT_TAPS),
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(DEFAULT_SEED),
  parameter int               NREQ  = 4,
  parameter int               STEPS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  output logic [NREQ-1:0]         gnt,
  output logic                    rnd_valid,
  output logic [WIDTH-1:0]        rnd_data,
  output logic [$clog2(NREQ)-1:0] rnd_id,
  input  logic                    seed_load,
  input  logic [WIDTH-1:0]        seed_val,
  output logic                    busy
);

  localparam int IDW = $clog2(NREQ);
  localparam int CW  = $clog2(STEPS) + 1;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] lfsr, lfsr_nxt, lfsr_step;
  logic [IDW-1:0]   rr_ptr, ptr_nxt;
  logic [IDW-1:0]   id_q, id_nxt;
  logic [CW-1:0]    step_cnt, cnt_nxt;
  logic             deliver;
  logic             pick_any;
  logic [IDW-1:0]   pick_idx;

  assign lfsr_step = WIDTH'(lfsr_next(LFSR_MAX_W'(lfsr), LFSR_MAX_W'(TAPS), WIDTH));
  assign busy      = (state != IDLE);

  lfsr_rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
    .req    (req),
    .rr_ptr (rr_ptr),
    .any    (pick_any),
    .idx    (pick_idx)
  );

  // State register; reset aborts any transaction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and datapath next values; seed loading beats a new request.
  always_comb begin
    state_nxt = state;
    lfsr_nxt  = lfsr;
    cnt_nxt   = step_cnt;
    id_nxt    = id_q;
    ptr_nxt   = rr_ptr;
    deliver   = 1'b0;
    case (state)
      IDLE: begin
        if (seed_load) begin
          lfsr_nxt = (seed_val == '0) ? SEED : seed_val;
        end else begin
`ifdef LFSR_FREE_RUN_EN
          lfsr_nxt = lfsr_step;
`else
          lfsr_nxt = lfsr;
`endif
          if (pick_any) begin
            id_nxt    = pick_idx;
            cnt_nxt   = CW'(STEPS - 1);
            state_nxt = ADVANCE;
          end
        end
      end
      ADVANCE: begin
        lfsr_nxt = lfsr_step;
        if (step_cnt == '0) state_nxt = DELIVER;
        else                cnt_nxt   = step_cnt - CW'(1);
      end
      DELIVER: begin
        deliver   = 1'b1;
        state_nxt = IDLE;
        ptr_nxt   = (id_q == IDW'(NREQ - 1)) ? '0 : id_q + IDW'(1);
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath registers: LFSR, step counter, latched winner, round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr     <= SEED;
      step_cnt <= '0;
      id_q     <= '0;
      rr_ptr   <= '0;
    end else begin
      lfsr     <= lfsr_nxt;
      step_cnt <= cnt_nxt;
      id_q     <= id_nxt;
      rr_ptr   <= ptr_nxt;
    end
  end

  // Registered delivery outputs; data and id hold between deliveries.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt       <= '0;
      rnd_valid <= 1'b0;
      rnd_data  <= '0;
      rnd_id    <= '0;
    end else begin
      rnd_valid <= deliver;
      gnt       <= deliver ? ({{(NREQ-1){1'b0}}, 1'b1} << id_q) : '0;
      if (deliver) begin
        rnd_data <= lfsr;
        rnd_id   <= id_q;
      end
    end
  end

endmodule

// File: tb/tb_lfsr_rng_arbiter.sv
// Self-checking bench for lfsr_rng_arbiter (default build, free-run off).
module tb_lfsr_rng_arbiter;

  localparam int          WIDTH   = 32;
  localparam int          NREQ    = 4;
  localparam int          STEPS   = 4;
  localparam logic [31:0] TB_TAPS = 32'h80200003;
  localparam logic [31:0] TB_SEED = 32'h00000001;

  logic              clk;
  logic              rst;
  logic [NREQ-1:0]   req;
  logic [NREQ-1:0]   gnt;
  logic              rnd_valid;
  logic [WIDTH-1:0]  rnd_data;
  logic [1:0]        rnd_id;
  logic              seed_load;
  logic [WIDTH-1:0]  seed_val;
  logic              busy;

  int          checks;
  int          failures;
  logic [31:0] m_lfsr;
  int          m_ptr;

  lfsr_rng_arbiter #(
    .WIDTH (WIDTH),
    .TAPS  (TB_TAPS),
    .SEED  (TB_SEED),
    .NREQ  (NREQ),
    .STEPS (STEPS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .gnt       (gnt),
    .rnd_valid (rnd_valid),
    .rnd_data  (rnd_data),
    .rnd_id    (rnd_id),
    .seed_load (seed_load),
    .seed_val  (seed_val),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: apply n shifts, feedback = parity of the tapped bits.
  function automatic logic [31:0] m_advance(input logic [31:0] v, input int n);
    logic [31:0] x;
    int ones;
    x = v;
    for (int s = 0; s < n; s++) begin
      ones = 0;
      for (int b = 0; b < 32; b++)
        if (TB_TAPS[b] && x[b]) ones++;
      x = {x[30:0], 1'b0} + 32'(ones % 2);
    end
    return x;
  endfunction

  // Reference: first asserted request at or after ptr, wrapping.
  function automatic int m_pick(input logic [3:0] r, input int ptr);
    for (int k = 0; k < NREQ; k++)
      if (r[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    return -1;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst    = 1'b0;
    m_lfsr = TB_SEED;
    m_ptr  = 0;
  endtask

  // Waits for the next delivery, checks latency (edges from call) and contents.
  task automatic expect_grant(input int exp_edges, input logic [3:0] pick_req, input string tag);
    int n;
    int exp_id;
    logic [31:0] exp_word;
    logic [3:0]  exp_gnt;
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (rnd_valid === 1'b1) begin
        n = i;
        break;
      end
    end
    checks++;
    if (n != exp_edges) begin
      failures++;
      $display("[TB] FAIL %s_latency: got %0d edges, expected %0d", tag, n, exp_edges);
    end
    if (n != 0) begin
      exp_id   = m_pick(pick_req, m_ptr);
      exp_word = m_advance(m_lfsr, STEPS);
      exp_gnt  = 4'b0001 << exp_id;
      checks++;
      if (rnd_data !== exp_word) begin
        failures++;
        $display("[TB] FAIL %s_data: got %h, expected %h", tag, rnd_data, exp_word);
      end
      checks++;
      if (rnd_id !== 2'(exp_id)) begin
        failures++;
        $display("[TB] FAIL %s_id: got %0d, expected %0d", tag, rnd_id, exp_id);
      end
      checks++;
      if (gnt !== exp_gnt) begin
        failures++;
        $display("[TB] FAIL %s_gnt: got %b, expected %b", tag, gnt, exp_gnt);
      end
      checks++;
      if (busy !== 1'b0) begin
        failures++;
        $display("[TB] FAIL %s_busy: got %b, expected 0", tag, busy);
      end
      m_lfsr = exp_word;
      m_ptr  = (exp_id + 1) % NREQ;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({gnt, rnd_valid, rnd_data, rnd_id, busy} !== '0) begin
      failures++;
      $display("[TB] FAIL reset_outputs: got gnt=%b valid=%b data=%h id=%0d busy=%b, expected all 0",
               gnt, rnd_valid, rnd_data, rnd_id, busy);
    end
    rst    = 1'b0;
    m_lfsr = TB_SEED;
    m_ptr  = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    req = 4'b0001;
    expect_grant(STEPS + 2, 4'b0001, "single1");
    checks++;
    if (rnd_data !== 32'h0000001B) begin
      failures++;
      $display("[TB] FAIL single1_word: got %h, expected 0000001b", rnd_data);
    end
    @(posedge clk); #1;
    checks++;
    if (rnd_valid !== 1'b0 || gnt !== 4'b0000 || rnd_data !== 32'h0000001B || busy !== 1'b1) begin
      failures++;
      $display("[TB] FAIL single_hold: got valid=%b gnt=%b data=%h busy=%b, expected 0 0000 0000001b 1",
               rnd_valid, gnt, rnd_data, busy);
    end
    expect_grant(STEPS + 1, 4'b0001, "single2");
    req = 4'b0000;
    checks++;
    if (rnd_data !== 32'h000001B6) begin
      failures++;
      $display("[TB] FAIL single2_word: got %h, expected 000001b6", rnd_data);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    req = 4'b1111;
    for (int g = 0; g < 8; g++) begin
      expect_grant((g == 0) ? STEPS + 2 : STEPS + 1, 4'b1111, "rr");
      checks++;
      if (rnd_id !== 2'(g % NREQ)) begin
        failures++;
        $display("[TB] FAIL rr_order: got %0d, expected %0d", rnd_id, g % NREQ);
      end
      if (g == 7) begin
        req = 4'b0000;
      end else begin
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b1 || gnt !== 4'b0000) begin
          failures++;
          $display("[TB] FAIL rr_gap: got busy=%b gnt=%b, expected 1 0000", busy, gnt);
        end
      end
    end
  endtask

  task automatic test_seed_zero();
    @(posedge clk); #1;
    seed_load = 1'b1;
    seed_val  = 32'h0;
    @(posedge clk); #1;
    seed_load = 1'b0;
    m_lfsr    = TB_SEED;
    req       = 4'b0100;
    expect_grant(STEPS + 2, 4'b0100, "seed_zero");
    req = 4'b0000;
    checks++;
    if (rnd_data !== 32'h0000001B || rnd_id !== 2'd2) begin
      failures++;
      $display("[TB] FAIL seed_zero_word: got %h id %0d, expected 0000001b id 2", rnd_data, rnd_id);
    end
  endtask

  task automatic test_seed_priority();
    @(posedge clk); #1;
    seed_load = 1'b1;
    seed_val  = 32'h1;
    req       = 4'b0010;
    @(posedge clk); #1;
    seed_load = 1'b0;
    m_lfsr    = 32'h1;
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL seed_priority: got busy=%b, expected 0", busy);
    end
    expect_grant(STEPS + 2, 4'b0010, "seed_same");
    // Seed load while the transaction is advancing must not disturb the word.
    @(posedge clk); #1;
    seed_load = 1'b1;
    seed_val  = $urandom | 32'h1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    seed_load = 1'b0;
    expect_grant(STEPS - 1, 4'b0010, "seed_advance");
    req = 4'b0000;
  endtask

  task automatic test_reset_mid();
    bit saw_gnt;
    saw_gnt = 1'b0;
    @(posedge clk); #1;
    req = 4'b1000;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    checks++;
    if ({gnt, rnd_valid, rnd_data, rnd_id, busy} !== '0) begin
      failures++;
      $display("[TB] FAIL abort_outputs: got gnt=%b valid=%b data=%h id=%0d busy=%b, expected all 0",
               gnt, rnd_valid, rnd_data, rnd_id, busy);
    end
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (gnt !== 4'b0000) saw_gnt = 1'b1;
    end
    checks++;
    if (saw_gnt) begin
      failures++;
      $display("[TB] FAIL abort_gnt: got a grant pulse, expected none");
    end
    rst    = 1'b0;
    m_lfsr = TB_SEED;
    m_ptr  = 0;
    expect_grant(STEPS + 2, 4'b1000, "after_abort");
    req = 4'b0000;
    checks++;
    if (rnd_data !== 32'h0000001B) begin
      failures++;
      $display("[TB] FAIL after_abort_word: got %h, expected 0000001b", rnd_data);
    end
  endtask

  task automatic test_random();
    logic [3:0]  r;
    logic [31:0] sv;
    for (int it = 0; it < 30; it++) begin
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #1;
      end
      if ($urandom_range(0, 3) == 0) begin
        sv        = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
        seed_load = 1'b1;
        seed_val  = sv;
        @(posedge clk); #1;
        seed_load = 1'b0;
        m_lfsr    = (sv == 32'h0) ? TB_SEED : sv;
      end
      r   = 4'($urandom_range(1, 15));
      req = r;
      if ($urandom_range(0, 1) == 1) begin
        // Request changes after selection are ignored; winner still granted.
        @(posedge clk); #1;
        req = 4'($urandom_range(0, 15));
        expect_grant(STEPS + 1, r, "random_drop");
      end else begin
        expect_grant(STEPS + 2, r, "random");
      end
      req = 4'b0000;
    end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    req       = '0;
    seed_load = 1'b0;
    seed_val  = '0;
    m_lfsr    = TB_SEED;
    m_ptr     = 0;
    test_reset();
    test_single();
    test_round_robin();
    test_seed_zero();
    test_seed_priority();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
